// File: rtl/instr_encoder_loader.sv
// Program loader: encodes symbolic commands into MIPS words
// and streams them to instruction memory at sequential addresses.
module instr_encoder_loader #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              finish,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        cmd,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  input  logic [4:0]        rd,
  input  logic [15:0]       imm,
  input  logic [ADDR_W-1:0] target,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   count,
  output logic              err_illegal,
  output logic              err_range,
  output logic              err_full
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic              pend_q, pend_d;
  logic              wr_valid_q, wr_valid_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [31:0]       wr_data_q, wr_data_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              ill_q, ill_d;
  logic              rng_q, rng_d;
  logic              full_q, full_d;

  logic [ADDR_W:0]   acc;
  logic [31:0]       tgt32, acc32, off32;
  logic              tgt_oob, off_oob;
  logic              is_ill, bad_rng, is_full;
  logic              accept, wdone;
  logic [31:0]       enc;

  // Address the next accepted word will occupy: written words
  // plus the one still held on the write port.
  assign acc   = count_q + {{ADDR_W{1'b0}}, wr_valid_q};
  assign tgt32 = 32'(target);
  assign acc32 = 32'(acc);
  assign off32 = tgt32 - acc32 - 32'd1;

  assign tgt_oob = tgt32 >= 32'(DEPTH);
  assign off_oob = ($signed(off32) > 32'sd32767) ||
                   ($signed(off32) < -32'sd32768);
  assign is_full = acc32 >= 32'(DEPTH);

  assign in_ready = (state_q == S_LOAD) & ~pend_q &
                    (~wr_valid_q | wr_ready);
  assign accept   = in_valid & in_ready;
  assign wdone    = wr_valid_q & wr_ready;

  // Command encoder and drop classification.
  always_comb begin
    enc     = '0;
    is_ill  = 1'b0;
    bad_rng = 1'b0;
    unique case (cmd)
      4'd0:  enc = {6'b0, rs, rt, rd, 5'd0, 6'b100000};
      4'd1:  enc = {6'b0, rs, rt, rd, 5'd0, 6'b100010};
      4'd2:  enc = {6'b0, rs, rt, rd, 5'd0, 6'b100100};
      4'd3:  enc = {6'b0, rs, rt, rd, 5'd0, 6'b100101};
      4'd4:  enc = {6'b0, rs, rt, rd, 5'd0, 6'b101010};
      4'd5:  enc = {6'b0, 5'd0, rt, rd, imm[4:0], 6'b000000};
      4'd6:  enc = {6'b100011, rs, rt, imm};
      4'd7:  enc = {6'b101011, rs, rt, imm};
      4'd8: begin
        enc     = {6'b000100, rs, rt, off32[15:0]};
        bad_rng = tgt_oob | off_oob;
      end
      4'd9:  enc = {6'b001000, rs, rt, imm};
      4'd10: begin
        enc     = {6'b000010, tgt32[25:0]};
        bad_rng = tgt_oob;
      end
      default: is_ill = 1'b1;
    endcase
  end

  // Session control, write-port holding and sticky error flags.
  always_comb begin
    state_d    = state_q;
    pend_d     = pend_q;
    wr_valid_d = wr_valid_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    count_d    = count_q;
    ill_d      = ill_q;
    rng_d      = rng_q;
    full_d     = full_q;
    if (wdone) begin
      wr_valid_d = 1'b0;
      count_d    = count_q + 1'b1;
    end
    unique case (state_q)
      S_LOAD: begin
        if (finish) pend_d = 1'b1;
        if (accept) begin
          if (is_ill | bad_rng | is_full) begin
            ill_d  = ill_q | is_ill;
            rng_d  = rng_q | bad_rng;
            full_d = full_q | is_full;
          end else begin
            wr_valid_d = 1'b1;
            wr_addr_d  = acc[ADDR_W-1:0];
            wr_data_d  = enc;
          end
        end else if (pend_q & ~wr_valid_q) begin
          state_d = S_DONE;
        end
      end
      default: begin
        if (start) begin
          state_d = S_LOAD;
          pend_d  = 1'b0;
          count_d = '0;
          ill_d   = 1'b0;
          rng_d   = 1'b0;
          full_d  = 1'b0;
        end
      end
    endcase
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      pend_q     <= 1'b0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      count_q    <= '0;
      ill_q      <= 1'b0;
      rng_q      <= 1'b0;
      full_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      wr_valid_q <= wr_valid_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      count_q    <= count_d;
      ill_q      <= ill_d;
      rng_q      <= rng_d;
      full_q     <= full_d;
    end
  end

  assign wr_valid    = wr_valid_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign count       = count_q;
  assign busy        = state_q == S_LOAD;
  assign done        = state_q == S_DONE;
  assign err_illegal = ill_q;
  assign err_range   = rng_q;
  assign err_full    = full_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Bench for instr_encoder_loader: directed scenarios plus a
// randomized run against a word-queue reference model.
module tb_instr_encoder_loader;
  localparam int AW = 8;
  localparam int DP = 20;

  logic          clk = 0;
  logic          rst_n = 0;
  logic          start = 0;
  logic          finish = 0;
  logic          in_valid = 0;
  logic          in_ready;
  logic [3:0]    cmd = 0;
  logic [4:0]    rs = 0, rt = 0, rd = 0;
  logic [15:0]   imm = 0;
  logic [AW-1:0] target = 0;
  logic          wr_valid;
  logic          wr_ready = 0;
  logic [AW-1:0] wr_addr;
  logic [31:0]   wr_data;
  logic          busy, done;
  logic [AW:0]   count;
  logic          err_illegal, err_range, err_full;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  instr_encoder_loader #(.ADDR_W(AW), .DEPTH(DP)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .finish(finish),
    .in_valid(in_valid), .in_ready(in_ready), .cmd(cmd),
    .rs(rs), .rt(rt), .rd(rd), .imm(imm), .target(target),
    .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .count(count),
    .err_illegal(err_illegal), .err_range(err_range),
    .err_full(err_full)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cmd(input int c, a, b, d, im, t);
    cmd = 4'(c); rs = 5'(a); rt = 5'(b); rd = 5'(d);
    imm = 16'(im); target = AW'(t);
  endtask

  // Reference encoding built from field weights.
  function automatic bit [31:0] ref_word(int c, a, b, d, im, t, addr);
    longint m26 = 64'h4000000;
    longint w = 0;
    int off;
    int fn[5] = '{32, 34, 36, 37, 42};
    case (c)
      0, 1, 2, 3, 4: w = a * 2**21 + b * 2**16 + d * 2**11 + fn[c];
      5:  w = b * 2**16 + d * 2**11 + (im % 32) * 64;
      6:  w = 35 * m26 + a * 2**21 + b * 2**16 + im;
      7:  w = 43 * m26 + a * 2**21 + b * 2**16 + im;
      8: begin
        off = t - (addr + 1);
        w = 4 * m26 + a * 2**21 + b * 2**16 + (off & 65535);
      end
      9:  w = 8 * m26 + a * 2**21 + b * 2**16 + im;
      10: w = 2 * m26 + t;
      default: w = 0;
    endcase
    return w[31:0];
  endfunction

  task automatic test_reset();
    #3;
    n_cmp++;
    if (wr_valid !== 1'b0) begin n_bad++;
      $display("FAIL reset_wr_valid got %b want 0", wr_valid); end
    n_cmp++;
    if (wr_addr !== 8'h0 || wr_data !== 32'h0) begin n_bad++;
      $display("FAIL reset_wr got %h/%h want 0/0", wr_addr, wr_data); end
    n_cmp++;
    if (count !== 9'd0) begin n_bad++;
      $display("FAIL reset_count got %0d want 0", count); end
    n_cmp++;
    if ({busy, done, err_illegal, err_range, err_full, in_ready} !== 6'b0) begin
      n_bad++;
      $display("FAIL reset_flags got %b want 000000",
               {busy, done, err_illegal, err_range, err_full, in_ready});
    end
    @(negedge clk);
    rst_n = 1;
    tick();
  endtask

  task automatic test_basic();
    start = 1; tick(); start = 0;
    set_cmd(0, 1, 2, 3, 0, 0); in_valid = 1; wr_ready = 0;
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b1 || in_ready !== 1'b1) begin n_bad++;
      $display("FAIL basic_ready got busy=%b rdy=%b want 1/1", busy, in_ready); end
    tick(); in_valid = 0;
    @(negedge clk);
    n_cmp++;
    if (wr_valid !== 1'b1 || wr_addr !== 8'd0 || wr_data !== 32'h00221820) begin
      n_bad++;
      $display("FAIL basic_add got v=%b a=%0d d=%h want 1/0/00221820",
               wr_valid, wr_addr, wr_data);
    end
    set_cmd(6, 29, 8, 0, 4, 0); in_valid = 1; wr_ready = 1;
    tick(); in_valid = 0; wr_ready = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if (wr_valid !== 1'b1 || wr_addr !== 8'd1 || wr_data !== 32'h8FA80004 ||
          in_ready !== 1'b0 || count !== 9'd1) begin
        n_bad++;
        $display("FAIL stall_%0d got v=%b a=%0d d=%h rdy=%b c=%0d want 1/1/8fa80004/0/1",
                 i, wr_valid, wr_addr, wr_data, in_ready, count);
      end
      tick();
    end
    wr_ready = 1; tick(); wr_ready = 0;
    @(negedge clk);
    n_cmp++;
    if (count !== 9'd2 || wr_valid !== 1'b0) begin n_bad++;
      $display("FAIL stall_done got c=%0d v=%b want 2/0", count, wr_valid); end
  endtask

  task automatic test_encodings();
    int c[6]  = '{9, 9, 9, 8, 10, 5};
    int a[6]  = '{0, 0, 0, 1, 0, 7};
    int b[6]  = '{1, 1, 1, 2, 0, 5};
    int d[6]  = '{0, 0, 0, 0, 0, 4};
    int im[6] = '{2, 3, 4, 0, 0, 2};
    int t[6]  = '{0, 0, 0, 2, 16, 0};
    bit [31:0] ex[6] = '{32'h20010002, 32'h20010003, 32'h20010004,
                         32'h1022FFFC, 32'h08000010, 32'h00052080};
    wr_ready = 1;
    for (int k = 0; k < 6; k++) begin
      set_cmd(c[k], a[k], b[k], d[k], im[k], t[k]); in_valid = 1;
      tick(); in_valid = 0;
      @(negedge clk);
      n_cmp++;
      if (wr_valid !== 1'b1 || wr_addr !== AW'(2 + k) || wr_data !== ex[k]) begin
        n_bad++;
        $display("FAIL enc_%0d got v=%b a=%0d d=%h want 1/%0d/%h",
                 k, wr_valid, wr_addr, wr_data, 2 + k, ex[k]);
      end
      tick();
    end
  endtask

  task automatic test_drops();
    set_cmd(12, 1, 2, 3, 0, 0); in_valid = 1;
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b1) begin n_bad++;
      $display("FAIL drop_ready got %b want 1", in_ready); end
    tick(); set_cmd(10, 0, 0, 0, 0, 250);
    tick(); set_cmd(8, 1, 2, 0, 0, 200);
    tick(); in_valid = 0;
    @(negedge clk);
    n_cmp++;
    if (wr_valid !== 1'b0 || count !== 9'd8) begin n_bad++;
      $display("FAIL drop_nowrite got v=%b c=%0d want 0/8", wr_valid, count); end
    n_cmp++;
    if ({err_illegal, err_range, err_full} !== 3'b110) begin n_bad++;
      $display("FAIL drop_flags got %b want 110",
               {err_illegal, err_range, err_full}); end
    set_cmd(9, 0, 3, 0, 77, 0); in_valid = 1;
    tick(); in_valid = 0;
    @(negedge clk);
    n_cmp++;
    if (wr_valid !== 1'b1 || wr_addr !== 8'd8 || wr_data !== 32'h2003004D) begin
      n_bad++;
      $display("FAIL drop_next got v=%b a=%0d d=%h want 1/8/2003004d",
               wr_valid, wr_addr, wr_data);
    end
    tick();
  endtask

  task automatic test_full_finish();
    for (int k = 0; k < 12; k++) begin
      set_cmd(9, 0, 1, 0, k, 0); in_valid = 1;
      @(negedge clk);
      n_cmp++;
      if (in_ready !== 1'b1) begin n_bad++;
        $display("FAIL full_rdy_%0d got %b want 1", k, in_ready); end
      if (k > 0) begin
        n_cmp++;
        if (wr_valid !== 1'b1 || wr_addr !== AW'(8 + k) ||
            wr_data !== 32'h20010000 + 32'(k - 1)) begin
          n_bad++;
          $display("FAIL full_wr_%0d got v=%b a=%0d d=%h want 1/%0d/%h",
                   k, wr_valid, wr_addr, wr_data, 8 + k,
                   32'h20010000 + 32'(k - 1));
        end
      end
      tick();
    end
    in_valid = 0;
    @(negedge clk);
    n_cmp++;
    if (count !== 9'd20 || err_full !== 1'b1 || wr_valid !== 1'b0) begin n_bad++;
      $display("FAIL full_state got c=%0d f=%b v=%b want 20/1/0",
               count, err_full, wr_valid); end
    finish = 1; tick(); finish = 0;
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b0) begin n_bad++;
      $display("FAIL fin_rdy got %b want 0", in_ready); end
    tick();
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b1 || busy !== 1'b0) begin n_bad++;
      $display("FAIL fin_done got d=%b b=%b want 1/0", done, busy); end
    start = 1; tick(); start = 0;
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b1 || count !== 9'd0 ||
        {err_illegal, err_range, err_full} !== 3'b0) begin
      n_bad++;
      $display("FAIL restart got b=%b c=%0d e=%b want 1/0/000",
               busy, count, {err_illegal, err_range, err_full});
    end
  endtask

  task automatic test_reset_mid();
    wr_ready = 0;
    set_cmd(1, 4, 5, 6, 0, 0); in_valid = 1;
    tick(); in_valid = 0;
    @(negedge clk);
    n_cmp++;
    if (wr_valid !== 1'b1) begin n_bad++;
      $display("FAIL rmid_pre got %b want 1", wr_valid); end
    #2 rst_n = 0;
    #1;
    n_cmp++;
    if (wr_valid !== 1'b0 || busy !== 1'b0 || count !== 9'd0) begin n_bad++;
      $display("FAIL rmid_async got v=%b b=%b c=%0d want 0/0/0",
               wr_valid, busy, count); end
    #1 rst_n = 1;
    in_valid = 1;
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b0 || busy !== 1'b0) begin n_bad++;
      $display("FAIL rmid_idle got rdy=%b b=%b want 0/0", in_ready, busy); end
    in_valid = 0;
    tick();
  endtask

  task automatic test_random();
    int qa[$];
    bit [31:0] qd[$];
    int ms = 0;
    int mcnt = 0, acc;
    bit pend = 0, mi = 0, mr = 0, mf = 0;
    bit rdy, hs, wd, idle_ok, il, rg, fl;
    int ci, ti;
    for (int cyc = 0; cyc < 400; cyc++) begin
      start = ($urandom_range(0, 15) == 0);
      finish = ($urandom_range(0, 24) == 0);
      in_valid = ($urandom_range(0, 3) != 0);
      ci = $urandom_range(0, 15);
      ti = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255)
                                       : $urandom_range(0, DP - 1);
      set_cmd(ci, $urandom_range(0, 31), $urandom_range(0, 31),
              $urandom_range(0, 31), $urandom_range(0, 65535), ti);
      wr_ready = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      rdy = (ms == 1) && !pend && (qa.size() == 0 || wr_ready);
      n_cmp++;
      if (in_ready !== rdy || wr_valid !== (qa.size() > 0)) begin n_bad++;
        $display("FAIL rnd_hs_%0d got rdy=%b v=%b want %b/%b",
                 cyc, in_ready, wr_valid, rdy, qa.size() > 0); end
      if (qa.size() > 0) begin
        n_cmp++;
        if (wr_addr !== AW'(qa[0]) || wr_data !== qd[0]) begin n_bad++;
          $display("FAIL rnd_wr_%0d got a=%0d d=%h want %0d/%h",
                   cyc, wr_addr, wr_data, qa[0], qd[0]); end
      end
      n_cmp++;
      if (count !== 9'(mcnt) || {err_illegal, err_range, err_full} !== {mi, mr, mf} ||
          busy !== (ms == 1) || done !== (ms == 2)) begin
        n_bad++;
        $display("FAIL rnd_st_%0d got c=%0d e=%b b=%b d=%b want %0d/%b/%b/%b",
                 cyc, count, {err_illegal, err_range, err_full}, busy, done,
                 mcnt, {mi, mr, mf}, ms == 1, ms == 2);
      end
      hs = in_valid && rdy;
      wd = (qa.size() > 0) && wr_ready;
      acc = mcnt + qa.size();
      idle_ok = pend && qa.size() == 0 && !hs;
      if (wd) begin
        void'(qa.pop_front());
        void'(qd.pop_front());
        mcnt++;
      end
      if (ms == 1) begin
        if (finish) pend = 1;
        if (hs) begin
          il = ci > 10;
          rg = (ci == 8 || ci == 10) && ti >= DP;
          fl = acc >= DP;
          mi |= il; mr |= rg; mf |= fl;
          if (!(il || rg || fl)) begin
            qa.push_back(acc);
            qd.push_back(ref_word(ci, int'(rs), int'(rt), int'(rd),
                                  int'(imm), ti, acc));
          end
        end else if (idle_ok) begin
          ms = 2;
        end
      end else if (start) begin
        ms = 1; mcnt = 0; pend = 0; mi = 0; mr = 0; mf = 0;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 0; start = 0; finish = 0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_encodings();
    test_drops();
    test_full_finish();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
